// File: rtl/voq_rd_scheduler.sv
// voq_rd_scheduler: read-side scheduler for the shared-buffer VOQ.
// Picks one eligible queue (non-empty, credit available, enabled) by
// round-robin, issues a one-cycle rd_en with rd_client held through the
// following HOLD cycle, and tags the returned cell with its output port.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             permits new grants (does not abort one in flight)
//   queue_empty        per-queue VOQ empty flags
//   credit_return      per-port one-cycle credit return pulses
//   rd_en, rd_client   VOQ read enable / queue select (registered)
//   out_valid,out_port VOQ rd_data valid this cycle and its destination
//   credit_err         sticky: credit returned to a port already full
module voq_rd_scheduler #(
  parameter int unsigned QUEUE_NUB   = 4,
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned CREDIT_INIT = 8,
  localparam int unsigned PTR_W      = (QUEUE_NUB > 1) ? $clog2(QUEUE_NUB) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [QUEUE_NUB-1:0] queue_empty,
  input  logic [QUEUE_NUB-1:0] credit_return,
  output logic                 rd_en,
  output logic [PTR_W-1:0]     rd_client,
  output logic                 out_valid,
  output logic [PTR_W-1:0]     out_port,
  output logic                 credit_err
);

  typedef enum logic [1:0] {ST_ARB, ST_RD, ST_HOLD} state_e;

  state_e                state_q;
  logic [PTR_W-1:0]      rr_ptr_q;
  logic [CREDIT_W-1:0]   credit_q [QUEUE_NUB];
  logic                  rd_en_q;
  logic [PTR_W-1:0]      rd_client_q;
  logic                  out_valid_q;
  logic [PTR_W-1:0]      out_port_q;
  logic                  credit_err_q;

  logic [QUEUE_NUB-1:0]  elig;
  logic                  grant_valid;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      rr_ptr_d;
  logic                  grant_fire;
  int unsigned           arb_idx;

  // Eligibility per queue
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < QUEUE_NUB; i++) begin
      elig[i] = enable && !queue_empty[i] && (credit_q[i] != '0);
    end
  end

  // Round-robin search starting at rr_ptr, first eligible queue wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    arb_idx     = 0;
    for (int unsigned k = 0; k < QUEUE_NUB; k++) begin
      arb_idx = (32'(rr_ptr_q) + k) % QUEUE_NUB;
      if (!grant_valid && elig[PTR_W'(arb_idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(arb_idx);
      end
    end
  end

  assign grant_fire = (state_q == ST_ARB) && grant_valid;
  // Explicit wrap so non-power-of-two queue counts stay in range
  assign rr_ptr_d   = (grant_idx == PTR_W'(QUEUE_NUB - 1)) ? '0 : grant_idx + PTR_W'(1);

  // FSM, read strobe/select, output tagging and credit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= '0;
      rd_en_q      <= 1'b0;
      rd_client_q  <= '0;
      out_valid_q  <= 1'b0;
      out_port_q   <= '0;
      credit_err_q <= 1'b0;
      for (int unsigned i = 0; i < QUEUE_NUB; i++) begin
        credit_q[i] <= CREDIT_W'(CREDIT_INIT);
      end
    end else begin
      case (state_q)
        ST_ARB: begin
          if (grant_fire) begin
            state_q     <= ST_RD;
            rd_en_q     <= 1'b1;
            rd_client_q <= grant_idx;
            rr_ptr_q    <= rr_ptr_d;
          end
        end
        ST_RD: begin
          // rd_client stays put: the VOQ pops with delayed rd_en + current rd_client
          state_q     <= ST_HOLD;
          rd_en_q     <= 1'b0;
          out_valid_q <= 1'b1;
          out_port_q  <= rd_client_q;
        end
        ST_HOLD: begin
          state_q     <= ST_ARB;
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_ARB;
          rd_en_q     <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase

      for (int unsigned i = 0; i < QUEUE_NUB; i++) begin
        if (grant_fire && (grant_idx == PTR_W'(i))) begin
          if (!credit_return[i]) credit_q[i] <= credit_q[i] - CREDIT_W'(1);
        end else if (credit_return[i]) begin
          if (credit_q[i] == CREDIT_W'(CREDIT_INIT)) credit_err_q <= 1'b1;
          else                                       credit_q[i] <= credit_q[i] + CREDIT_W'(1);
        end
      end
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_client  = rd_client_q;
  assign out_valid  = out_valid_q;
  assign out_port   = out_port_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_voq_rd_scheduler.sv
// Bench for voq_rd_scheduler: a small VOQ occupancy model feeds queue_empty,
// a monitor logs reads and output cells, tests compare logs to expectations.
module tb_voq_rd_scheduler;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [N-1:0] queue_empty;
  logic [N-1:0] credit_return;
  logic         rd_en;
  logic [1:0]   rd_client;
  logic         out_valid;
  logic [1:0]   out_port;
  logic         credit_err;

  typedef struct {int port; int client; int cyc;} ev_t;

  int   cnt[N];     // cells written into each queue (tests)
  int   popped[N];  // cells read out of each queue (monitor)
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;
  ev_t  rd_log[$];
  ev_t  ov_log[$];
  int   exp_q[$];

  voq_rd_scheduler #(.QUEUE_NUB(4), .CREDIT_W(4), .CREDIT_INIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .queue_empty(queue_empty),
    .credit_return(credit_return), .rd_en(rd_en), .rd_client(rd_client),
    .out_valid(out_valid), .out_port(out_port), .credit_err(credit_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) queue_empty[i] = (cnt[i] <= popped[i]);
  end

  // Monitor: VOQ pop on rd_en, log reads and delivered cells
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) popped[i] = 0;
    end else begin
      if (rd_en) begin
        rd_log.push_back('{int'(rd_client), int'(rd_client), cyc});
        popped[rd_client] = popped[rd_client] + 1;
      end
      if (out_valid) ov_log.push_back('{int'(out_port), int'(rd_client), cyc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    credit_return = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    tick(2);
    rd_log.delete();
    ov_log.delete();
    exp_q.delete();
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    c0 = cyc;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en); end
    checks++; if (rd_client !== 2'd0) begin errors++; $display("FAIL reset_rd_client: got %0d expected 0", rd_client); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_port !== 2'd0) begin errors++; $display("FAIL reset_out_port: got %0d expected 0", out_port); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err: got %0b expected 0", credit_err); end
    release_reset();
    tick(10);
    checks++; if (rd_log.size() != 0) begin errors++; $display("FAIL idle_rd_en: got %0d reads expected 0", rd_log.size()); end
    checks++; if (ov_log.size() != 0) begin errors++; $display("FAIL idle_out_valid: got %0d cells expected 0", ov_log.size()); end
    // All credits still 8: each queue gets exactly 8 grants in round-robin order
    for (int i = 0; i < N; i++) cnt[i] = 9;
    for (int k = 0; k < 32; k++) exp_q.push_back(k % N);
    tick(120);
    checks++; if (rd_log.size() != 32) begin errors++; $display("FAIL idle_credits: got %0d grants expected 32", rd_log.size()); end
    for (int k = 0; k < 32 && k < rd_log.size(); k++) begin
      int e;
      e = exp_q.pop_front();
      checks++; if (rd_log[k].port != e) begin errors++; $display("FAIL idle_credit_order[%0d]: got %0d expected %0d", k, rd_log[k].port, e); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 3;
    for (int k = 0; k < 12; k++) exp_q.push_back(k % N);
    release_reset();
    tick(50);
    checks++; if (rd_log.size() != 12) begin errors++; $display("FAIL rr_count: got %0d expected 12", rd_log.size()); end
    checks++; if (ov_log.size() != 12) begin errors++; $display("FAIL rr_cells: got %0d expected 12", ov_log.size()); end
    if (rd_log.size() > 0) begin
      checks++; if (rd_log[0].cyc != c0 + 1) begin errors++; $display("FAIL rr_latency: got %0d expected %0d", rd_log[0].cyc, c0 + 1); end
    end
    for (int k = 0; k < 12 && k < rd_log.size() && k < ov_log.size(); k++) begin
      int e;
      e = exp_q.pop_front();
      checks++; if (rd_log[k].port != e) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, rd_log[k].port, e); end
      checks++; if (rd_log[k].cyc != rd_log[0].cyc + 3 * k) begin errors++; $display("FAIL rr_period[%0d]: got %0d expected %0d", k, rd_log[k].cyc, rd_log[0].cyc + 3 * k); end
      checks++; if (ov_log[k].port != e) begin errors++; $display("FAIL rr_out_port[%0d]: got %0d expected %0d", k, ov_log[k].port, e); end
      checks++; if (ov_log[k].client != e) begin errors++; $display("FAIL rr_hold_client[%0d]: got %0d expected %0d", k, ov_log[k].client, e); end
      checks++; if (ov_log[k].cyc != rd_log[k].cyc + 1) begin errors++; $display("FAIL rr_out_timing[%0d]: got %0d expected %0d", k, ov_log[k].cyc, rd_log[k].cyc + 1); end
    end
  endtask

  task automatic test_single_cell();
    do_reset();
    cnt[2] = 1;
    release_reset();
    tick(30);
    checks++; if (rd_log.size() != 1) begin errors++; $display("FAIL single_reads: got %0d expected 1", rd_log.size()); end
    checks++; if (ov_log.size() != 1) begin errors++; $display("FAIL single_cells: got %0d expected 1", ov_log.size()); end
    if (rd_log.size() > 0 && ov_log.size() > 0) begin
      checks++; if (rd_log[0].port != 2) begin errors++; $display("FAIL single_client: got %0d expected 2", rd_log[0].port); end
      checks++; if (ov_log[0].port != 2) begin errors++; $display("FAIL single_out_port: got %0d expected 2", ov_log[0].port); end
      checks++; if (ov_log[0].cyc != c0 + 2) begin errors++; $display("FAIL single_out_timing: got %0d expected %0d", ov_log[0].cyc, c0 + 2); end
    end
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    cnt[1] = 20;
    release_reset();
    tick(40);
    checks++; if (rd_log.size() != 8) begin errors++; $display("FAIL exhaust_grants: got %0d expected 8", rd_log.size()); end
    for (int k = 0; k < rd_log.size(); k++) begin
      checks++; if (rd_log[k].port != 1) begin errors++; $display("FAIL exhaust_client[%0d]: got %0d expected 1", k, rd_log[k].port); end
    end
    credit_return = 4'b0010;
    tick(1);
    credit_return = '0;
    tick(20);
    checks++; if (rd_log.size() != 9) begin errors++; $display("FAIL exhaust_return: got %0d expected 9", rd_log.size()); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL exhaust_err: got %0b expected 0", credit_err); end
  endtask

  task automatic test_credit_err();
    do_reset();
    release_reset();
    tick(2);
    credit_return = 4'b0001;
    tick(1);
    credit_return = '0;
    tick(1);
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b expected 1", credit_err); end
    tick(5);
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", credit_err); end
    cnt[0] = 20;
    tick(40);
    checks++; if (rd_log.size() != 8) begin errors++; $display("FAIL err_saturate: got %0d grants expected 8", rd_log.size()); end
    // Grant and return on port 3 in the same cycle: net zero, no error
    do_reset();
    cnt[3] = 20;
    credit_return = 4'b1000;
    release_reset();
    tick(1);
    credit_return = '0;
    tick(45);
    checks++; if (rd_log.size() != 9) begin errors++; $display("FAIL both_grants: got %0d expected 9", rd_log.size()); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL both_err: got %0b expected 0", credit_err); end
  endtask

  task automatic test_enable_drop();
    int k;
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 5;
    release_reset();
    k = 0;
    while (!rd_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL en_wait_rd: got %0b expected 1 within 20 cycles", rd_en); end
    enable = 1'b0;
    tick(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL en_out_valid: got %0b expected 1", out_valid); end
    checks++; if (out_port !== 2'd0) begin errors++; $display("FAIL en_out_port: got %0d expected 0", out_port); end
    tick(10);
    checks++; if (rd_log.size() != 1) begin errors++; $display("FAIL en_no_grant: got %0d expected 1", rd_log.size()); end
    enable = 1'b1;
    tick(10);
    checks++; if (rd_log.size() < 2) begin errors++; $display("FAIL en_resume: got %0d reads expected >=2", rd_log.size()); end
    else begin
      checks++; if (rd_log[1].port != 1) begin errors++; $display("FAIL en_resume_client: got %0d expected 1", rd_log[1].port); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    credit_return = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    test_reset();
    test_round_robin();
    test_single_cell();
    test_credit_exhaust();
    test_credit_err();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
